reg_dump: RTL and testbench

REG_DUMP -- requirements
Module: reg_dump

---
 rtl/reg_dump_pkg.sv | 7 +
 rtl/reg_dump.sv | 82 ++++++++
 tb/tb_reg_dump.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: FSM state type and bank geometry defaults shared with the register file.
package reg_dump_pkg;
  localparam int NREG_D = 32;
  localparam int DW_D = 32;
  localparam int AW_D = 5;
  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;
endpackage

// File: rtl/reg_dump.sv
// reg_dump: streams a wrapping register range out of a register-file read port over valid/ready.
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int NREG = NREG_D,
  parameter int DW = DW_D,
  parameter int AW = AW_D
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] first_reg,
  input  logic [AW-1:0] last_reg,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          done
);
  localparam int CW = $clog2(NREG + 1);
  state_t r_state, w_state_nx;
  logic [CW-1:0] r_rem, w_count;
  logic [AW-1:0] r_rd_addr, r_addr, w_addr_nx;
  logic [DW-1:0] r_data;
  logic w_start, w_capture, w_hs;
  // r_rem counts words not yet captured, so the held word is final once it reaches zero
  assign w_count = CW'((first_reg <= last_reg) ? int'(last_reg) - int'(first_reg) + 1
                                               : int'(last_reg) + NREG - int'(first_reg) + 1);
  assign w_addr_nx = (r_rd_addr == AW'(NREG - 1)) ? '0 : r_rd_addr + AW'(1);
  assign w_hs = (r_state == SEND) && out_ready;
  always_comb begin
    w_state_nx = r_state;
    w_start = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        w_start = start && !abort;
        w_state_nx = w_start ? LOAD : IDLE;
      end
      LOAD: begin
        w_capture = !abort;
        w_state_nx = abort ? IDLE : SEND;
      end
      SEND: begin
        w_capture = !abort && w_hs && (r_rem != '0);
        w_state_nx = abort ? IDLE : (w_hs && r_rem == '0) ? DONE : SEND;
      end
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_addr <= '0;
      r_rem <= '0;
      r_data <= '0;
      r_addr <= '0;
    end else if (w_start) begin
      r_rd_addr <= first_reg;
      r_rem <= w_count;
    end else if (w_capture) begin
      r_data <= rd_data;
      r_addr <= r_rd_addr;
      r_rd_addr <= w_addr_nx;
      r_rem <= r_rem - CW'(1);
    end
  end
  assign rd_addr = r_rd_addr;
  assign out_data = r_data;
  assign out_addr = r_addr;
  assign out_valid = r_state == SEND;
  assign out_last = (r_state == SEND) && (r_rem == '0);
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: randomized scoreboard bench; expected words come from a range model over the bank array.
module tb_reg_dump;
  logic clk = 1'b0;
  logic rst_n, start, abort, out_ready, out_valid, out_last, busy, done;
  logic [4:0] first_reg, last_reg, rd_addr, out_addr;
  logic [31:0] rd_data, out_data;
  logic [31:0] bank [32];
  typedef struct packed {logic [31:0] d; logic [4:0] a; logic l;} exp_t;
  exp_t exp_q[$];
  exp_t prev;
  bit hold_prev, rdy_rand;
  int errors = 0, checks = 0, done_cnt = 0;

  reg_dump dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .first_reg(first_reg), .last_reg(last_reg), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  assign rd_data = bank[rd_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rdy_rand) out_ready = 1'($urandom);
  endtask

  task automatic push_range(input int f, input int l);
    int n, a;
    n = ((l - f) % 32 + 32) % 32 + 1;
    for (int k = 0; k < n; k++) begin
      a = (f + k) % 32;
      exp_q.push_back({bank[a], 5'(a), k == n - 1});
    end
  endtask

  task automatic dump(input int f, input int l, input bit lat, input int hold, input bit meddle);
    int d0, g;
    push_range(f, l);
    d0 = done_cnt;
    g = 0;
    if (hold > 0) begin
      rdy_rand = 0;
      out_ready = 0;
    end
    first_reg = 5'(f);
    last_reg = 5'(l);
    start = 1;
    step();
    start = 0;
    if (lat) begin
      chk("lat_edge1_valid", 64'(out_valid), 0);
      chk("lat_edge1_busy", 64'(busy), 1);
      step();
      chk("lat_edge2_valid", 64'(out_valid), 1);
    end
    if (hold > 0) begin
      while (!out_valid && g < 50) begin
        step();
        g++;
      end
      repeat (hold - 1) step();
      chk("hold_valid", 64'(out_valid), 1);
      chk("hold_last", 64'(out_last), 1);
      chk("hold_data", 64'(out_data), 64'(bank[f]));
      out_ready = 1;
    end
    g = 0;
    while (done_cnt == d0 && g < 400) begin
      if (meddle) begin
        start = g < 2;
        first_reg = 5'(f + 5);
        last_reg = 5'(l + 9);
      end
      step();
      g++;
    end
    start = 0;
    if (g >= 400) chk("dump_timeout", 1, 0);
    chk("busy_after_done", 64'(busy), 0);
    repeat (3) step();
    chk("done_once", 64'(done_cnt - d0), 1);
    chk("queue_drained", 64'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (!rst_n) hold_prev = 0;
    else begin
      if (done) done_cnt++;
      if (hold_prev && out_valid)
        chk("hold_stable", {out_data, out_addr, out_last}, prev);
      if (out_valid && out_ready && !abort) begin
        if (exp_q.size() == 0) chk("unexpected_word", {out_data, out_addr, out_last}, 0);
        else chk("word", {out_data, out_addr, out_last}, exp_q.pop_front());
      end
      hold_prev = out_valid && !out_ready && !abort;
      prev = {out_data, out_addr, out_last};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int d0;
    rst_n = 0; start = 0; abort = 0; out_ready = 1; rdy_rand = 0;
    first_reg = 0; last_reg = 0;
    foreach (bank[i]) bank[i] = 32'(i * 3);
    #12;
    chk("reset_outputs", {rd_addr, out_data, out_addr, out_valid, out_last, busy, done}, 0);
    rst_n = 1;
    step();
    dump(4, 7, 1, 0, 0);
    dump(30, 1, 1, 0, 0);
    dump(9, 9, 0, 5, 0);
    abort = 1; start = 1; first_reg = 0; last_reg = 3;
    step();
    step();
    chk("abort_start_idle_busy", 64'(busy), 0);
    chk("abort_start_idle_valid", 64'(out_valid), 0);
    abort = 0; start = 0;
    step();
    d0 = done_cnt;
    exp_q.push_back({32'd12, 5'd4, 1'b0});
    first_reg = 4; last_reg = 7; start = 1;
    step();
    start = 0;
    step();
    step();
    chk("abort_word1_shown", 64'(out_addr), 5);
    abort = 1;
    step();
    abort = 0;
    chk("abort_outputs", {out_valid, out_last, busy, done}, 0);
    repeat (3) step();
    chk("abort_no_done", 64'(done_cnt - d0), 0);
    chk("abort_queue", 64'(exp_q.size()), 0);
    exp_q.delete();
    dump(4, 7, 0, 0, 0);
    rdy_rand = 1;
    foreach (bank[i]) bank[i] = $urandom;
    dump(0, 31, 0, 0, 0);
    repeat (6) dump(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 0, 0, 0);
    push_range(0, 31);
    first_reg = 0; last_reg = 31; start = 1;
    step();
    start = 0;
    repeat (5) step();
    #3 rst_n = 0;
    #1 chk("async_reset_outputs", {rd_addr, out_data, out_addr, out_valid, out_last, busy, done}, 0);
    exp_q.delete();
    step();
    step();
    rst_n = 1;
    step();
    rdy_rand = 1;
    dump(10, 20, 1, 0, 1);
    dump(28, 2, 0, 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
